// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for in-order data-SRAM responses, aligns and
// extends load data per byte lane, and drives the write-back and forward buses.

module mem_stage_lane #(
  parameter int LANE  = 0,
  parameter int VEC_W = 8
) (
  input  logic [3:0][VEC_W-1:0] word,
  input  logic [VEC_W-1:0]      res_byte,
  input  logic [1:0]            p,
  input  logic [6:0]            ld_inst,
  output logic [VEC_W-1:0]      byte_out,
  output logic                  wen
);
  localparam logic [1:0] L = 2'(LANE);

  logic [2:0]       sum;
  logic [1:0]       lwl_idx;
  logic [VEC_W-1:0] b_sel, h_sel;
  logic             b_sign, h_sign;

  // lane L of lwl takes source byte L-(3-p); lane L of lwr takes source byte L+p
  assign sum     = {1'b0, L} + {1'b0, p};
  assign lwl_idx = 2'(sum - 3'd3);
  assign b_sel   = word[p];
  assign h_sel   = word[{p[1], L[0]}];
  assign b_sign  = b_sel[VEC_W-1];
  assign h_sign  = word[{p[1], 1'b1}][VEC_W-1];

  always_comb begin
    byte_out = res_byte;
    wen      = 1'b1;
    if (ld_inst[6])      byte_out = word[L];
    else if (ld_inst[5]) byte_out = (L == 2'd0) ? b_sel : {VEC_W{b_sign}};
    else if (ld_inst[4]) byte_out = (L == 2'd0) ? b_sel : '0;
    else if (ld_inst[3]) byte_out = (L < 2'd2) ? h_sel : {VEC_W{h_sign}};
    else if (ld_inst[2]) byte_out = (L < 2'd2) ? h_sel : '0;
    else if (ld_inst[1]) begin
      wen      = (sum >= 3'd3);
      byte_out = wen ? word[lwl_idx] : '0;
    end else if (ld_inst[0]) begin
      wen      = (sum <= 3'd3);
      byte_out = wen ? word[sum[1:0]] : '0;
    end
  end
endmodule

module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 128,
  parameter int MS_TO_WS_BUS_WD = 123,
  parameter int MS_FWD_BUS_WD   = 40
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       es_to_ms_req,
  input  logic                       es_req_accept,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
  output logic                       ms_ex,
  input  logic                       flush
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef struct packed {
    logic [31:0] badvaddr;
    logic [10:0] c0_bus;
    logic        bd;
    logic        ex;
    logic [4:0]  excode;
    logic [6:0]  ld_inst;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] res;
    logic [31:0] pc;
  } es_bus_t;

  typedef struct packed {
    logic [31:0] badvaddr;
    logic [10:0] c0_bus;
    logic        bd;
    logic        ex;
    logic [4:0]  excode;
    logic [3:0]  rf_wen;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ws_bus_t;

  es_bus_t                             ms_bus;
  ws_bus_t                             ws_bus;
  logic                                ms_valid, ms_req, got;
  logic [1:0]                          out_cnt, dis_cnt;
  logic [31:0]                         buf_data;
  logic                                resp_ok, capture, ms_ready_go, leave;
  logic [NUM_LANES-1:0][VEC_W-1:0]     word, res_b, result;
  logic [NUM_LANES-1:0]                wen;

  // a response belongs to the stage only once all pre-flush responses have drained
  assign resp_ok     = data_sram_data_ok && (dis_cnt == 2'd0);
  assign capture     = ms_valid && ms_req && !got && resp_ok;
  assign ms_ready_go = !ms_req || got || resp_ok;
  assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
  assign leave       = ms_valid && ms_ready_go && ws_allowin;

  always_ff @(posedge clk) begin
    if (reset)                ms_valid <= 1'b0;
    else if (flush)           ms_valid <= 1'b0;
    else if (ms_allowin)      ms_valid <= es_to_ms_valid;

    if (es_to_ms_valid && ms_allowin) begin
      ms_bus <= es_bus_t'(es_to_ms_bus);
      ms_req <= es_to_ms_req;
    end

    if (reset || flush)       got <= 1'b0;
    else if (leave)           got <= 1'b0;
    else if (capture)         got <= 1'b1;

    if (capture) buf_data <= data_sram_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt <= 2'd0;
      dis_cnt <= 2'd0;
    end else begin
      out_cnt <= out_cnt + 2'(es_req_accept) - 2'(data_sram_data_ok);
      if (flush)
        dis_cnt <= out_cnt + 2'(es_req_accept) - 2'(data_sram_data_ok);
      else if (dis_cnt != 2'd0 && data_sram_data_ok)
        dis_cnt <= dis_cnt - 2'd1;
    end
  end

  assign word  = got ? buf_data : data_sram_rdata;
  assign res_b = ms_bus.res;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mem_stage_lane #(.LANE(i), .VEC_W(VEC_W)) u_lane (
      .word     (word),
      .res_byte (res_b[i]),
      .p        (ms_bus.res[1:0]),
      .ld_inst  (ms_bus.ld_inst),
      .byte_out (result[i]),
      .wen      (wen[i])
    );
  end

  always_comb begin
    ws_bus.badvaddr = ms_bus.badvaddr;
    ws_bus.c0_bus   = ms_bus.c0_bus;
    ws_bus.bd       = ms_bus.bd;
    ws_bus.ex       = ms_bus.ex;
    ws_bus.excode   = ms_bus.excode;
    ws_bus.rf_wen   = wen & {4{ms_bus.gr_we && !ms_bus.ex}};
    ws_bus.dest     = ms_bus.dest;
    ws_bus.result   = result;
    ws_bus.pc       = ms_bus.pc;
  end

  assign ms_to_ws_bus   = ws_bus;
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
  assign ms_ex          = ms_valid && ms_bus.ex;
  assign ms_fwd_bus     = {ms_valid && ms_bus.c0_bus[8],
                           ms_valid && ms_bus.res_from_mem && !ms_ready_go,
                           ms_valid && ms_bus.gr_we && !flush,
                           ms_bus.dest,
                           32'(result)};
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed stall/flush/reset
// sequences, and an output scoreboard fed as instructions are issued.

module tb_mem_stage;
  logic         clk = 1'b0;
  logic         reset, ws_allowin, ms_allowin, es_to_ms_valid, es_to_ms_req;
  logic         es_req_accept, data_sram_data_ok, ms_to_ws_valid, ms_ex, flush;
  logic [127:0] es_to_ms_bus;
  logic [31:0]  data_sram_rdata;
  logic [122:0] ms_to_ws_bus;
  logic [39:0]  ms_fwd_bus;

  mem_stage dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .es_to_ms_req(es_to_ms_req), .es_req_accept(es_req_accept),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ms_fwd_bus(ms_fwd_bus), .ms_ex(ms_ex), .flush(flush)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b1000000, LB = 7'b0100000, LBU = 7'b0010000,
                         LH = 7'b0001000, LHU = 7'b0000100, LWL = 7'b0000010,
                         LWR = 7'b0000001, NOP = 7'b0000000;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  wen;
    logic [4:0]  dest;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [6:0]  ld;
    logic [31:0] addr;
    logic [31:0] data;
    logic        req;
    logic [31:0] r;
    logic [3:0]  w;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        tv[13];
  int          checks = 0, errors = 0;
  logic [31:0] pc_n = 32'hbfc0_0000;
  logic [10:0] cur_c0 = 11'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [6:0] ld, input logic [31:0] addr,
                                input logic [31:0] d, input logic gr_we, input logic ex,
                                output logic [31:0] r, output logic [3:0] w);
    logic [1:0]  p;
    logic [7:0]  b;
    logic [15:0] h;
    p = addr[1:0];
    b = 8'(d >> (8 * p));
    h = p[1] ? d[31:16] : d[15:0];
    w = 4'hf;
    if (ld == LW)       r = d;
    else if (ld == LB)  r = {{24{b[7]}}, b};
    else if (ld == LBU) r = {24'h0, b};
    else if (ld == LH)  r = {{16{h[15]}}, h};
    else if (ld == LHU) r = {16'h0, h};
    else if (ld == LWL) begin r = d << (8 * (3 - p)); w = 4'hf << (3 - p); end
    else if (ld == LWR) begin r = d >> (8 * p);       w = 4'hf >> p;       end
    else                r = addr;
    w = w & {4{gr_we && !ex}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    es_to_ms_valid    = 1'b0;
    es_to_ms_req      = 1'b0;
    es_req_accept     = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    flush             = 1'b0;
    ws_allowin        = 1'b1;
  endtask

  task automatic send(input logic [6:0] ld, input logic [31:0] addr, input logic req,
                      input logic gr_we, input logic ex, input logic [31:0] er,
                      input logic [3:0] ew, input logic push);
    exp_t e;
    e.result = er; e.wen = ew; e.dest = pc_n[6:2]; e.pc = pc_n;
    es_to_ms_valid = 1'b1;
    es_to_ms_req   = req;
    es_req_accept  = req;
    es_to_ms_bus   = {addr, cur_c0, 1'b0, ex, (ex ? 5'h04 : 5'h00), ld, (ld != NOP),
                      gr_we, pc_n[6:2], addr, pc_n};
    if (push) sb.push_back(e);
    pc_n = pc_n + 32'd4;
  endtask

  task automatic send_model(input logic [6:0] ld, input logic [31:0] addr, input logic req,
                            input logic gr_we, input logic ex, input logic [31:0] d);
    logic [31:0] r;
    logic [3:0]  w;
    model(ld, addr, d, gr_we, ex, r, w);
    send(ld, addr, req, gr_we, ex, r, w, 1'b1);
  endtask

  // scoreboard: every word handed to write-back must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      if (sb.size() == 0) begin
        chk("unexpected_output_pc", ms_to_ws_bus[31:0], 32'hffff_ffff);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_result", ms_to_ws_bus[63:32], mon_e.result);
        chk("sb_rf_wen", 32'(ms_to_ws_bus[72:69]), 32'(mon_e.wen));
        chk("sb_dest", 32'(ms_to_ws_bus[68:64]), 32'(mon_e.dest));
        chk("sb_pc", ms_to_ws_bus[31:0], mon_e.pc);
      end
    end
  end

  initial begin
    tv[0]  = '{LB,  32'h1003, 32'h80112233, 1'b1, 32'hFFFFFF80, 4'b1111};
    tv[1]  = '{LBU, 32'h1003, 32'h80112233, 1'b1, 32'h00000080, 4'b1111};
    tv[2]  = '{LWL, 32'h1001, 32'hAABBCCDD, 1'b1, 32'hCCDD0000, 4'b1100};
    tv[3]  = '{LWR, 32'h1002, 32'hAABBCCDD, 1'b1, 32'h0000AABB, 4'b0011};
    tv[4]  = '{LW,  32'h1000, 32'hAABBCCDD, 1'b1, 32'hAABBCCDD, 4'b1111};
    tv[5]  = '{LH,  32'h1002, 32'h80011234, 1'b1, 32'hFFFF8001, 4'b1111};
    tv[6]  = '{LHU, 32'h1000, 32'hAABBCCDD, 1'b1, 32'h0000CCDD, 4'b1111};
    tv[7]  = '{LWL, 32'h1003, 32'hAABBCCDD, 1'b1, 32'hAABBCCDD, 4'b1111};
    tv[8]  = '{LWL, 32'h1000, 32'hAABBCCDD, 1'b1, 32'hDD000000, 4'b1000};
    tv[9]  = '{LWR, 32'h1003, 32'hAABBCCDD, 1'b1, 32'h000000AA, 4'b0001};
    tv[10] = '{LB,  32'h1001, 32'hAABBCCDD, 1'b1, 32'hFFFFFFCC, 4'b1111};
    tv[11] = '{NOP, 32'h12345678, 32'h0,    1'b0, 32'h12345678, 4'b1111};
    tv[12] = '{LH,  32'h1000, 32'h00007FFF, 1'b1, 32'h00007FFF, 4'b1111};

    idle();
    es_to_ms_bus = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ms_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    chk("rst_ms_allowin", 32'(ms_allowin), 32'd1);
    chk("rst_ms_ex", 32'(ms_ex), 32'd0);
    chk("rst_fwd_ctrl", 32'(ms_fwd_bus[39:37]), 32'd0);
    tick();

    // one-cycle loads/ALU ops: response arrives in the first cycle in the stage
    for (int i = 0; i < 13; i++) begin
      send(tv[i].ld, tv[i].addr, tv[i].req, 1'b1, 1'b0, tv[i].r, tv[i].w, 1'b1);
      tick();
      idle();
      data_sram_data_ok = tv[i].req;
      data_sram_rdata   = tv[i].data;
      @(negedge clk);
      chk("vec_one_cycle_valid", 32'(ms_to_ws_valid), 32'd1);
      tick();
    end

    // lhu whose response is three cycles late
    send(LHU, 32'h2000, 1'b1, 1'b1, 1'b0, 32'h0000CCDD, 4'b1111, 1'b1);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("late_load_not_ready", 32'(ms_fwd_bus[38]), 32'd1);
      chk("late_no_valid", 32'(ms_to_ws_valid), 32'd0);
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hAABBCCDD;
    @(negedge clk);
    chk("late_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("late_ready_fwd", 32'(ms_fwd_bus[38]), 32'd0);
    tick();

    // response arrives while write-back is stalled for two cycles
    idle();
    send(LW, 32'h3000, 1'b1, 1'b1, 1'b0, 32'h11223344, 4'b1111, 1'b1);
    tick();
    idle();
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h11223344;
    @(negedge clk);
    chk("stall_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("stall_allowin", 32'(ms_allowin), 32'd0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEADBEEF;
    @(negedge clk);
    chk("stall_buf_result", ms_to_ws_bus[63:32], 32'h11223344);
    tick();
    ws_allowin = 1'b1;
    @(negedge clk);
    chk("stall_release_allowin", 32'(ms_allowin), 32'd1);
    tick();
    idle();
    send(LW, 32'h3004, 1'b1, 1'b1, 1'b0, 32'h55667788, 4'b1111, 1'b1);
    tick();
    idle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h55667788;
    @(negedge clk);
    chk("after_stall_valid", 32'(ms_to_ws_valid), 32'd1);
    tick();

    // flush with two responses outstanding: both are dropped, the third is used
    idle();
    send(NOP, 32'h4000, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    es_req_accept = 1'b1;
    tick();
    idle();
    ws_allowin    = 1'b0;
    es_req_accept = 1'b1;
    @(negedge clk);
    chk("pre_flush_valid", 32'(ms_to_ws_valid), 32'd1);
    tick();
    idle();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle_valid", 32'(ms_to_ws_valid), 32'd0);
    chk("flush_block_valid", 32'(ms_fwd_bus[37]), 32'd0);
    tick();
    idle();
    send(LW, 32'h4100, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D, 4'b1111, 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0BAD0001;
    @(negedge clk);
    chk("post_flush_allowin", 32'(ms_allowin), 32'd1);
    chk("post_flush_valid", 32'(ms_to_ws_valid), 32'd0);
    tick();
    idle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0BAD0002;
    @(negedge clk);
    chk("discard_second_valid", 32'(ms_to_ws_valid), 32'd0);
    chk("discard_second_lnr", 32'(ms_fwd_bus[38]), 32'd1);
    tick();
    data_sram_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("third_resp_valid", 32'(ms_to_ws_valid), 32'd1);
    tick();

    // excepting load
    idle();
    send_model(LW, 32'h5001, 1'b0, 1'b1, 1'b1, 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("exc_ms_ex", 32'(ms_ex), 32'd1);
    chk("exc_rf_wen", 32'(ms_to_ws_bus[72:69]), 32'd0);
    chk("exc_badvaddr", ms_to_ws_bus[122:91], 32'h5001);
    chk("exc_excode", 32'(ms_to_ws_bus[77:73]), 32'h4);
    tick();

    // mfc0 forward flag and forwarded ALU result
    cur_c0 = 11'h100;
    send_model(NOP, 32'h0000_6060, 1'b0, 1'b1, 1'b0, 32'h0);
    cur_c0 = 11'h0;
    tick();
    idle();
    @(negedge clk);
    chk("mfc0_valid", 32'(ms_fwd_bus[39]), 32'd1);
    chk("fwd_block_valid", 32'(ms_fwd_bus[37]), 32'd1);
    chk("fwd_result", ms_fwd_bus[31:0], 32'h0000_6060);
    tick();

    // reset while discards are pending must clear the counters
    send(LW, 32'h7000, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    tick();
    idle();
    flush         = 1'b1;
    es_req_accept = 1'b1;
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(ms_to_ws_valid), 32'd0);
    chk("mid_rst_allowin", 32'(ms_allowin), 32'd1);
    tick();
    send_model(LW, 32'h7100, 1'b1, 1'b1, 1'b0, 32'h0BADF00D);
    tick();
    idle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0BADF00D;
    @(negedge clk);
    chk("after_rst_valid", 32'(ms_to_ws_valid), 32'd1);
    tick();

    // random one-cycle loads checked against the reference model
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a, d;
      logic [6:0]  ld;
      a  = $urandom;
      d  = $urandom;
      ld = 7'(7'd1 << $urandom_range(0, 6));
      idle();
      send_model(ld, a, 1'b1, 1'b1, 1'b0, d);
      tick();
      idle();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = d;
      @(negedge clk);
      chk("rand_valid", 32'(ms_to_ws_valid), 32'd1);
      tick();
    end

    idle();
    tick(); tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and the write-back stage. It accepts the 128-bit execute-to-memory bus and waits for the in-order data-SRAM response of any request the execute stage issued. It then aligns and sign/zero-extends load data, including lwl/lwr byte-merge enables, and hands a 123-bit bus to write-back. It also drives the memory-stage forward bus, and on flush it discards all data-SRAM responses still in flight.

## Interface
- ES_TO_MS_BUS_WD, 128: input bus width. Fields: badvaddr[127:96], c0_bus[95:85], bd[84], ex[83], excode[82:78], ld_inst[77:71] = {lw,lb,lbu,lh,lhu,lwl,lwr}, res_from_mem[70], gr_we[69], dest[68:64], res[63:32] (ALU result / address), pc[31:0].
- MS_TO_WS_BUS_WD, 123: output bus width. Fields: badvaddr[122:91], c0_bus[90:80], bd[79], ex[78], excode[77:73], rf_wen[72:69], dest[68:64], result[63:32], pc[31:0].
- MS_FWD_BUS_WD, 40: forward bus width. Fields: mfc0_valid[39], load_not_ready[38], block_valid[37], dest[36:32], result[31:0].
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ws_allowin  in  1  write-back can accept.
- ms_allowin  out  1  this stage can accept.
- es_to_ms_valid  in  1  execute bus valid.
- es_to_ms_bus  in  128  execute payload.
- es_to_ms_req  in  1  sampled with the bus: this instruction owns an accepted data-SRAM request.
- es_req_accept  in  1  pulse: execute got addr_ok this cycle.
- data_sram_data_ok  in  1  response valid, in request order.
- data_sram_rdata  in  32  response word.
- ms_to_ws_valid  out  1  output bus valid.
- ms_to_ws_bus  out  123  write-back payload.
- ms_fwd_bus  out  40  forward/bypass info.
- ms_ex  out  1  valid instruction carries an exception.
- flush  in  1  exception/eret flush, one-cycle pulse.

## Operation
- Input register: ms_valid <= es_to_ms_valid when ms_allowin. The bus and es_to_ms_req are latched on es_to_ms_valid && ms_allowin.
- flush: ms_valid <= 0 the next cycle, overriding any new load.
- Outstanding counter out_cnt (2 bits, max 2): +1 on es_req_accept, −1 on data_ok; both together leaves it unchanged.
- Discard counter dis_cnt (2 bits). On flush, dis_cnt <= out_cnt + es_req_accept − data_ok.
- While dis_cnt ≠ 0, each data_ok decrements dis_cnt and is not consumed by the stage.
- Response capture: when ms_valid && ms_req && !got && dis_cnt==0 && data_ok, capture data_sram_rdata.
  - If ms_ready_go && ws_allowin in the same cycle, consume it directly.
  - Otherwise store it in buf_data and set got=1.
  - got clears when the instruction leaves or on flush.
- ms_ready_go = !ms_req || got || (data_ok && dis_cnt==0).
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_valid && ms_ready_go && !flush.
- Load data: word = got ? buf_data : rdata. Let p = res[1:0].
  - lw: word, wen 1111.
  - lb/lbu: byte p, sign-/zero-extended, wen 1111.
  - lh/lhu: half p[1], sign-/zero-extended, wen 1111.
  - lwl: result word<<(8·(3−p)); wen p=0:1000, p=1:1100, p=2:1110, p=3:1111.
  - lwr: result word>>(8·p); wen p=0:1111, p=1:0111, p=2:0011, p=3:0001.
- Non-load instructions: result = res, wen = 1111.
- rf_wen = wen & {4{gr_we && !ex}}.
- Exception fields (badvaddr, c0_bus, bd, ex, excode) pass through unchanged.
- ms_ex = ms_valid && ex.
- Forward bus:
  - block_valid = ms_valid && gr_we && !flush.
  - load_not_ready = ms_valid && res_from_mem && !ms_ready_go.
  - mfc0_valid = ms_valid && c0_bus[8].
  - result is the final aligned result.

## Timing
- Reset values: ms_valid, got, out_cnt and dis_cnt are 0, so ms_to_ws_valid=0, ms_allowin=1, ms_ex=0, and the forward bus control bits are 0.
- Non-memory instruction: one cycle in the stage.
- Load whose data_ok arrives in its first cycle: one cycle.
- Otherwise the stage stalls until data_ok; the output is combinational from rdata in the data_ok cycle.
- Response held by ws stall: buf_data is stable and the output is unchanged until ws_allowin.
- Flush with the stage's own response still pending: that response and every other in-flight response are dropped.
- The first instruction after the flush sees dis_cnt==0 before its own response is captured.
- reset mid-request clears all counters; no response is expected after reset.

## Test plan
- lb, address 0x...03, data_ok in cycle 1 with rdata 0x80112233 -> result 0xFFFFFF80, rf_wen 1111, one-cycle latency.
- lwl, p=1, rdata 0xAABBCCDD -> result 0xCCDD0000, rf_wen 1100. lwr, p=2 -> result 0x0000AABB, rf_wen 0011.
- lhu with data_ok 3 cycles late -> load_not_ready=1 for 3 cycles, then ms_to_ws_valid for one cycle with result 0x0000CCDD (p=0).
- data_ok arrives while ws_allowin=0 for 2 cycles -> buffered word is emitted intact when ws_allowin rises, and the following load gets its own data.
- Flush with out_cnt=2 -> the next two data_ok pulses are ignored, the next load receives the third response, and ms_to_ws_valid is 0 in the flush cycle.
- Excepting load (ex=1, gr_we=1) -> rf_wen 0000, ms_ex=1, badvaddr and excode unchanged.
